// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit conditional-sum adder, LS nibble first,
// with a registered inter-nibble carry and valid/ready handshakes on both sides.

module nibble_serial_adder_csa4 (
   input  logic [3:0] i_x,
   input  logic [3:0] i_y,
   input  logic       i_cin,
   output logic [3:0] o_s,
   output logic       o_cout
);
   logic [4:0] w_sum0;
   logic [4:0] w_sum1;

   // Both carry-in hypotheses are formed in parallel; cin only selects.
   assign w_sum0 = {1'b0, i_x} + {1'b0, i_y};
   assign w_sum1 = w_sum0 + 5'd1;
   assign {o_cout, o_s} = i_cin ? w_sum1 : w_sum0;
endmodule

module nibble_serial_adder #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout
);
   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_sum;
   logic           r_carry;
   logic           r_cout;
   logic [CW-1:0]  r_cnt;
   logic [3:0]     w_x;
   logic [3:0]     w_y;
   logic [3:0]     w_s;
   logic           w_co;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)       w_next = S_RUN;
         S_RUN:   if (r_cnt == LAST)  w_next = S_DONE;
         S_DONE:  if (out_ready)      w_next = S_IDLE;
         default:                     w_next = S_IDLE;
      endcase
   end

   // Nibble mux driven by the counter; out-of-range counts select nibble 0.
   always_comb begin
      w_x = r_a[3:0];
      w_y = r_b[3:0];
      for (int unsigned k = 0; k < NIBBLES; k++) begin
         if (r_cnt == k[CW-1:0]) begin
            w_x = r_a[4*k +: 4];
            w_y = r_b[4*k +: 4];
         end
      end
   end

   nibble_serial_adder_csa4 u_csa (
      .i_x    (w_x),
      .i_y    (w_y),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_sum   <= '0;
               end
            end
            S_RUN: begin
               for (int unsigned k = 0; k < NIBBLES; k++) begin
                  if (r_cnt == k[CW-1:0]) r_sum[4*k +: 4] <= w_s;
               end
               r_carry <= w_co;
               if (r_cnt == LAST) r_cout <= w_co;
               else               r_cnt  <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
endmodule
